// File: rtl/dispatch_controller_if.sv
// dispatch_controller_if
//   Decoder/back-end handshake bundle for the dispatch controller.
//   master : decoder / release sources (drives the decode controls, releases, commit, flush)
//   slave  : dispatch_controller (drives accept/stall, write enables, ROB tag, free counts, creditErr)
//   ROB_DEPTH sizes robTag and robFree. It must match the controller's ROB_DEPTH.
interface dispatch_controller_if #(
    parameter int ROB_DEPTH = 8
);
    localparam int RW = $clog2(ROB_DEPTH);

    logic          instrValid;
    logic          stationRequest;
    logic [1:0]    RSstation;
    logic          robWrite;
    logic          aluRelease;
    logic          brRelease;
    logic          robCommit;
    logic          flush;

    logic          instrAccept;
    logic          stall;
    logic          aluRSWrite;
    logic          brRSWrite;
    logic          robAlloc;
    logic [RW-1:0] robTag;
    logic [3:0]    aluFree;
    logic [3:0]    brFree;
    logic [RW:0]   robFree;
    logic          creditErr;

    modport master (
        output instrValid, stationRequest, RSstation, robWrite,
               aluRelease, brRelease, robCommit, flush,
        input  instrAccept, stall, aluRSWrite, brRSWrite, robAlloc,
               robTag, aluFree, brFree, robFree, creditErr
    );

    modport slave (
        input  instrValid, stationRequest, RSstation, robWrite,
               aluRelease, brRelease, robCommit, flush,
        output instrAccept, stall, aluRSWrite, brRSWrite, robAlloc,
               robTag, aluFree, brFree, robFree, creditErr
    );
endinterface

// File: rtl/dispatch_controller.sv
// dispatch_controller
//   Credit-based dispatch scheduler. It dispatches one decoded instruction per
//   cycle when its target reservation station (ALU or branch) and a ROB slot
//   are free, and stalls otherwise. A flush empties every resource through a
//   one-cycle RECOVER state.
//   clk    : clock, rising edge
//   resetN : asynchronous active-low reset
//   dif    : dispatch_controller_if.slave. Decode controls, releases, commit
//            and flush come in. Accept, stall, write enables, robTag, free
//            counts and the sticky creditErr go out.
module dispatch_controller #(
    parameter int ALU_RS_DEPTH = 4,
    parameter int BR_RS_DEPTH  = 4,
    parameter int ROB_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    dispatch_controller_if.slave  dif
);
    localparam int RW = $clog2(ROB_DEPTH);
    localparam logic [3:0]  ALU_FULL = 4'(ALU_RS_DEPTH);
    localparam logic [3:0]  BR_FULL  = 4'(BR_RS_DEPTH);
    localparam logic [RW:0] ROB_FULL = (RW+1)'(ROB_DEPTH);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [3:0]    alu_free_q, alu_free_d;
    logic [3:0]    br_free_q, br_free_d;
    logic [RW:0]   rob_free_q, rob_free_d;
    logic [RW-1:0] head_q, head_d;
    logic [RW-1:0] tail_q, tail_d;
    logic          cerr_q, cerr_d;

    logic dispatch_en;
    logic need_alu, need_br, need_rob, accept;
    logic alu_rel_ok, br_rel_ok, commit_ok, rel_err;

    // FSM: state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= RUN;
        else         state_q <= state_d;
    end

    // FSM: next state. A flush seen in either state (re)enters RECOVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (dif.flush) state_d = RECOVER;
            RECOVER: state_d = dif.flush ? RECOVER : RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: output. Dispatch and credit updates happen only in RUN with no flush.
    always_comb begin
        dispatch_en = (state_q == RUN) && !dif.flush;
    end

    // Dispatch decision uses registered counts only. Releases help next cycle.
    always_comb begin
        need_alu = dif.stationRequest && (dif.RSstation == 2'b00);
        need_br  = dif.stationRequest && (dif.RSstation == 2'b01);
        need_rob = dif.robWrite;
        accept   = dif.instrValid && dispatch_en &&
                   (!need_alu || (alu_free_q != '0)) &&
                   (!need_br  || (br_free_q  != '0)) &&
                   (!need_rob || (rob_free_q != '0));
    end

    assign dif.instrAccept = accept;
    assign dif.stall       = dif.instrValid && !accept;
    assign dif.aluRSWrite  = accept && need_alu;
    assign dif.brRSWrite   = accept && need_br;
    assign dif.robAlloc    = accept && need_rob;
    assign dif.robTag      = tail_q;
    assign dif.aluFree     = alu_free_q;
    assign dif.brFree      = br_free_q;
    assign dif.robFree     = rob_free_q;
    assign dif.creditErr   = cerr_q;

    // A release or commit against an already-full counter is dropped and
    // flagged. This keeps the counters bounded even if the back end misbehaves.
    always_comb begin
        alu_rel_ok = dif.aluRelease && (alu_free_q != ALU_FULL);
        br_rel_ok  = dif.brRelease  && (br_free_q  != BR_FULL);
        commit_ok  = dif.robCommit  && (rob_free_q != ROB_FULL);
        rel_err    = (dif.aluRelease && (alu_free_q == ALU_FULL)) ||
                     (dif.brRelease  && (br_free_q  == BR_FULL))  ||
                     (dif.robCommit  && (rob_free_q == ROB_FULL));
    end

    always_comb begin
        alu_free_d = alu_free_q;
        br_free_d  = br_free_q;
        rob_free_d = rob_free_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cerr_d     = cerr_q;
        if (!dispatch_en) begin
            // Flush cycle or RECOVER: all in-flight work is squashed, so every
            // resource is free again. The ROB restarts at the retire point.
            alu_free_d = ALU_FULL;
            br_free_d  = BR_FULL;
            rob_free_d = ROB_FULL;
            tail_d     = head_q;
        end else begin
            alu_free_d = alu_free_q + 4'(alu_rel_ok) - 4'(dif.aluRSWrite);
            br_free_d  = br_free_q  + 4'(br_rel_ok)  - 4'(dif.brRSWrite);
            rob_free_d = rob_free_q + (RW+1)'(commit_ok) - (RW+1)'(dif.robAlloc);
            // ROB_DEPTH is a power of two, so the pointers wrap by overflow.
            head_d     = head_q + RW'(commit_ok);
            tail_d     = tail_q + RW'(dif.robAlloc);
            cerr_d     = cerr_q || rel_err;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alu_free_q <= ALU_FULL;
            br_free_q  <= BR_FULL;
            rob_free_q <= ROB_FULL;
            head_q     <= '0;
            tail_q     <= '0;
            cerr_q     <= 1'b0;
        end else begin
            alu_free_q <= alu_free_d;
            br_free_q  <= br_free_d;
            rob_free_q <= rob_free_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cerr_q     <= cerr_d;
        end
    end
endmodule

// File: tb/tb_dispatch_controller.sv
// tb_dispatch_controller
//   Directed test of dispatch_controller with the default parameters
//   (ALU/BR depth 4, ROB depth 8). Inputs change just after the falling edge.
//   Combinational outputs are sampled 1 time unit later. Registered effects
//   are sampled after the following rising edge.
module tb_dispatch_controller;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    dispatch_controller_if #(.ROB_DEPTH(8)) dif ();

    dispatch_controller #(
        .ALU_RS_DEPTH(4),
        .BR_RS_DEPTH (4),
        .ROB_DEPTH   (8)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .dif   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dif.instrValid     = 1'b0;
        dif.stationRequest = 1'b0;
        dif.RSstation      = 2'b00;
        dif.robWrite       = 1'b0;
        dif.aluRelease     = 1'b0;
        dif.brRelease      = 1'b0;
        dif.robCommit      = 1'b0;
        dif.flush          = 1'b0;
    endtask

    task automatic set_op(input logic sr, input logic [1:0] rs, input logic rw);
        dif.instrValid     = 1'b1;
        dif.stationRequest = sr;
        dif.RSstation      = rs;
        dif.robWrite       = rw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Issue one op that must be accepted, then advance one cycle.
    task automatic acc_op(input string tag, input logic sr, input logic [1:0] rs,
                          input logic rw, input int tagv);
        set_op(sr, rs, rw);
        #1;
        chk({tag, ".acc"}, 32'(dif.instrAccept), 32'd1);
        if (rw) chk({tag, ".tag"}, 32'(dif.robTag), 32'(tagv));
        @(negedge clk);
    endtask

    initial begin
        idle();
        do_reset();
        // reset state
        #1;
        chk("rst.aluFree", 32'(dif.aluFree), 32'd4);
        chk("rst.brFree",  32'(dif.brFree),  32'd4);
        chk("rst.robFree", 32'(dif.robFree), 32'd8);
        chk("rst.robTag",  32'(dif.robTag),  32'd0);
        chk("rst.acc",     32'(dif.instrAccept), 32'd0);
        chk("rst.stall",   32'(dif.stall),   32'd0);
        chk("rst.cerr",    32'(dif.creditErr), 32'd0);

        // four back-to-back ALU ops, then the fifth stalls
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, 2'b00, 1'b1);
            #1;
            chk("alu4.acc",  32'(dif.instrAccept), 32'd1);
            chk("alu4.tag",  32'(dif.robTag), 32'(i));
            chk("alu4.wr",   32'(dif.aluRSWrite), 32'd1);
            chk("alu4.rob",  32'(dif.robAlloc), 32'd1);
            @(negedge clk);
        end
        chk("alu4.aluFree", 32'(dif.aluFree), 32'd0);
        chk("alu4.robFree", 32'(dif.robFree), 32'd4);
        #1;
        chk("alu5.stall", 32'(dif.stall), 32'd1);
        chk("alu5.acc",   32'(dif.instrAccept), 32'd0);
        chk("alu5.wr",    32'(dif.aluRSWrite), 32'd0);

        // release in cycle N: still stalled in N, accepted in N+1
        dif.aluRelease = 1'b1;
        #1;
        chk("rel.stallN", 32'(dif.stall), 32'd1);
        @(negedge clk);
        dif.aluRelease = 1'b0;
        #1;
        chk("rel.aluFree1", 32'(dif.aluFree), 32'd1);
        chk("rel.accN1",    32'(dif.instrAccept), 32'd1);
        chk("rel.tag",      32'(dif.robTag), 32'd4);
        @(negedge clk);
        idle();
        chk("rel.aluFree0", 32'(dif.aluFree), 32'd0);
        chk("rel.robFree",  32'(dif.robFree), 32'd3);

        // ROB wrap using JAL-style decodes
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_op(1'b0, 2'b00, 1'b1);
            #1;
            chk("jal.acc", 32'(dif.instrAccept), 32'd1);
            chk("jal.tag", 32'(dif.robTag), 32'(i));
            chk("jal.aluwr", 32'(dif.aluRSWrite), 32'd0);
            @(negedge clk);
        end
        chk("jal.robFree0", 32'(dif.robFree), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dif.robCommit = 1'b1;
            #1;
            chk("wrap.stall", 32'(dif.stall), 32'd1);
            @(negedge clk);
            dif.robCommit = 1'b0;
            #1;
            chk("wrap.robFree1", 32'(dif.robFree), 32'd1);
            chk("wrap.acc", 32'(dif.instrAccept), 32'd1);
            chk("wrap.tag", 32'(dif.robTag), 32'(i));
            @(negedge clk);
            chk("wrap.robFree0", 32'(dif.robFree), 32'd0);
        end
        idle();

        // branch alloc and release in the same cycle
        do_reset();
        acc_op("br", 1'b1, 2'b01, 1'b0, 0);
        acc_op("br", 1'b1, 2'b01, 1'b0, 0);
        chk("br.free2", 32'(dif.brFree), 32'd2);
        set_op(1'b1, 2'b01, 1'b0);
        dif.brRelease = 1'b1;
        #1;
        chk("br.wr",  32'(dif.brRSWrite), 32'd1);
        chk("br.rob", 32'(dif.robAlloc), 32'd0);
        @(negedge clk);
        idle();
        chk("br.same", 32'(dif.brFree), 32'd2);

        // flush with 3 ALU, 2 branch and 5 ROB entries in use
        do_reset();
        acc_op("fl.a", 1'b1, 2'b00, 1'b1, 0);
        acc_op("fl.a", 1'b1, 2'b00, 1'b1, 1);
        acc_op("fl.a", 1'b1, 2'b00, 1'b1, 2);
        acc_op("fl.b", 1'b1, 2'b01, 1'b1, 3);
        acc_op("fl.b", 1'b1, 2'b01, 1'b1, 4);
        acc_op("fl.j", 1'b0, 2'b00, 1'b1, 5);
        idle();
        dif.robCommit = 1'b1;
        @(negedge clk);
        dif.robCommit = 1'b0;
        chk("fl.pre.alu", 32'(dif.aluFree), 32'd1);
        chk("fl.pre.br",  32'(dif.brFree),  32'd2);
        chk("fl.pre.rob", 32'(dif.robFree), 32'd3);
        set_op(1'b1, 2'b00, 1'b1);
        dif.flush = 1'b1;
        dif.aluRelease = 1'b1;
        #1;
        chk("fl.N.acc",   32'(dif.instrAccept), 32'd0);
        chk("fl.N.stall", 32'(dif.stall), 32'd1);
        @(negedge clk);
        dif.flush = 1'b0;
        dif.aluRelease = 1'b0;
        #1;
        chk("fl.N1.acc", 32'(dif.instrAccept), 32'd0);
        chk("fl.aluFree", 32'(dif.aluFree), 32'd4);
        chk("fl.brFree",  32'(dif.brFree),  32'd4);
        chk("fl.robFree", 32'(dif.robFree), 32'd8);
        chk("fl.robTag",  32'(dif.robTag),  32'd1);
        @(negedge clk);
        #1;
        chk("fl.N2.acc", 32'(dif.instrAccept), 32'd1);
        chk("fl.N2.tag", 32'(dif.robTag), 32'd1);
        @(negedge clk);
        chk("fl.post.alu", 32'(dif.aluFree), 32'd3);
        chk("fl.post.rob", 32'(dif.robFree), 32'd7);

        // flush held for two cycles extends RECOVER by one cycle
        dif.flush = 1'b1;
        #1;
        chk("fl2.N.acc", 32'(dif.instrAccept), 32'd0);
        @(negedge clk);
        #1;
        chk("fl2.N1.acc", 32'(dif.instrAccept), 32'd0);
        @(negedge clk);
        dif.flush = 1'b0;
        #1;
        chk("fl2.N2.acc", 32'(dif.instrAccept), 32'd0);
        @(negedge clk);
        #1;
        chk("fl2.N3.acc", 32'(dif.instrAccept), 32'd1);
        chk("fl2.N3.tag", 32'(dif.robTag), 32'd1);
        @(negedge clk);
        idle();

        // release at full credit: ignored, sticky error until reset
        do_reset();
        dif.aluRelease = 1'b1;
        @(negedge clk);
        dif.aluRelease = 1'b0;
        chk("cerr.alu", 32'(dif.aluFree), 32'd4);
        chk("cerr.set", 32'(dif.creditErr), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("cerr.sticky", 32'(dif.creditErr), 32'd1);
        do_reset();
        #1;
        chk("cerr.clr", 32'(dif.creditErr), 32'd0);

        // default decode and "no station" code: accepted, consumes nothing
        set_op(1'b0, 2'b11, 1'b0);
        #1;
        chk("def.acc",   32'(dif.instrAccept), 32'd1);
        chk("def.stall", 32'(dif.stall), 32'd0);
        chk("def.we",    32'({dif.aluRSWrite, dif.brRSWrite, dif.robAlloc}), 32'd0);
        @(negedge clk);
        set_op(1'b1, 2'b10, 1'b0);
        #1;
        chk("nost.acc", 32'(dif.instrAccept), 32'd1);
        chk("nost.we",  32'({dif.aluRSWrite, dif.brRSWrite, dif.robAlloc}), 32'd0);
        @(negedge clk);
        idle();
        chk("def.alu", 32'(dif.aluFree), 32'd4);
        chk("def.br",  32'(dif.brFree),  32'd4);
        chk("def.rob", 32'(dif.robFree), 32'd8);
        chk("def.tag", 32'(dif.robTag),  32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
